// File: rtl/shift_result_packer.sv
// Buffers qualified shift-unit results in a small word FIFO and streams each
// word out as two bytes (LSB first) over a valid/ready byte interface.
module shift_result_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK_SHIFT,
    input  logic                  RST_SHIFT,
    input  logic [DATA_WIDTH-1:0] RES_IN,
    input  logic                  RES_VALID,
    output logic [BYTE_WIDTH-1:0] BYTE_OUT,
    output logic                  BYTE_VALID,
    input  logic                  BYTE_READY,
    output logic                  FIFO_EMPTY,
    output logic                  BUSY,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVF
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    state_t                state;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign head       = mem[rd_ptr];
    assign FIFO_EMPTY = (count == '0);

    // A full FIFO still accepts a word when the FSM pops on the same edge.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        if (count != '0) begin
            pop = (state == IDLE) || ((state == SEND_HI) && BYTE_READY);
        end
        if (RES_VALID) begin
            push = (count != CW'(FIFO_DEPTH)) || pop;
            drop = !push;
        end
    end

    always_ff @(posedge CLK_SHIFT) begin
        if (push) begin
            mem[wr_ptr] <= RES_IN;
        end
    end

    always_ff @(posedge CLK_SHIFT or negedge RST_SHIFT) begin
        if (!RST_SHIFT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK_SHIFT or negedge RST_SHIFT) begin
        if (!RST_SHIFT) begin
            OVERFLOW <= 1'b0;
        end else if (drop) begin
            OVERFLOW <= 1'b1;
        end else if (CLR_OVF) begin
            OVERFLOW <= 1'b0;
        end
    end

    // Byte outputs are registered alongside the state so they never depend
    // combinationally on BYTE_READY.
    always_ff @(posedge CLK_SHIFT or negedge RST_SHIFT) begin
        if (!RST_SHIFT) begin
            state      <= IDLE;
            hold       <= '0;
            BYTE_OUT   <= '0;
            BYTE_VALID <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold       <= head;
                        BYTE_OUT   <= head[BYTE_WIDTH-1:0];
                        BYTE_VALID <= 1'b1;
                        BUSY       <= 1'b1;
                        state      <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (BYTE_READY) begin
                        BYTE_OUT <= hold[DATA_WIDTH-1:BYTE_WIDTH];
                        state    <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (BYTE_READY) begin
                        if (pop) begin
                            hold     <= head;
                            BYTE_OUT <= head[BYTE_WIDTH-1:0];
                            state    <= SEND_LO;
                        end else begin
                            BYTE_OUT   <= '0;
                            BYTE_VALID <= 1'b0;
                            BUSY       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    BYTE_OUT   <= '0;
                    BYTE_VALID <= 1'b0;
                    BUSY       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_result_packer.sv
// Randomized and directed checks of shift_result_packer against a
// queue-based reference model of the word FIFO and the byte stream.
module tb_shift_result_packer;

    localparam int DEPTH = 4;

    logic        CLK_SHIFT  = 1'b0;
    logic        RST_SHIFT  = 1'b0;
    logic [15:0] RES_IN     = '0;
    logic        RES_VALID  = 1'b0;
    logic        BYTE_READY = 1'b0;
    logic        CLR_OVF    = 1'b0;
    logic [7:0]  BYTE_OUT;
    logic        BYTE_VALID;
    logic        FIFO_EMPTY;
    logic        BUSY;
    logic        OVERFLOW;

    always #5 CLK_SHIFT = ~CLK_SHIFT;

    shift_result_packer #(
        .DATA_WIDTH(16),
        .BYTE_WIDTH(8),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK_SHIFT (CLK_SHIFT),
        .RST_SHIFT (RST_SHIFT),
        .RES_IN    (RES_IN),
        .RES_VALID (RES_VALID),
        .BYTE_OUT  (BYTE_OUT),
        .BYTE_VALID(BYTE_VALID),
        .BYTE_READY(BYTE_READY),
        .FIFO_EMPTY(FIFO_EMPTY),
        .BUSY      (BUSY),
        .OVERFLOW  (OVERFLOW),
        .CLR_OVF   (CLR_OVF)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: words waiting in the FIFO, and bytes of the word in flight.
    logic [15:0] m_words[$];
    logic [7:0]  m_bytes[$];
    bit          m_ovf;
    logic [7:0]  dut_log[$];

    function automatic void model_reset();
        m_words.delete();
        m_bytes.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_edge();
        int          pre_size = m_words.size();
        bit          popped   = 1'b0;
        logic [15:0] w;
        if (m_bytes.size() > 0 && BYTE_READY) begin
            void'(m_bytes.pop_front());
        end
        if (m_bytes.size() == 0 && m_words.size() > 0) begin
            w = m_words.pop_front();
            m_bytes.push_back(w[7:0]);
            m_bytes.push_back(w[15:8]);
            popped = 1'b1;
        end
        if (RES_VALID && (pre_size < DEPTH || popped)) begin
            m_words.push_back(RES_IN);
        end else if (RES_VALID) begin
            m_ovf = 1'b1;
        end else if (CLR_OVF) begin
            m_ovf = 1'b0;
        end
        if (RES_VALID && (pre_size < DEPTH || popped) && CLR_OVF) begin
            m_ovf = 1'b0;
        end
    endfunction

    task automatic check_all();
        logic       exp_valid;
        logic [7:0] exp_out;
        exp_valid = (m_bytes.size() > 0);
        exp_out   = exp_valid ? m_bytes[0] : 8'h00;
        check("byte_valid", BYTE_VALID, exp_valid);
        check("byte_out", BYTE_OUT, exp_out);
        check("fifo_empty", FIFO_EMPTY, m_words.size() == 0);
        check("busy", BUSY, exp_valid);
        check("overflow", OVERFLOW, m_ovf);
    endtask

    // Inputs are stable from negedge to the next negedge; the model steps on posedge.
    task automatic cycle();
        if (BYTE_VALID && BYTE_READY) dut_log.push_back(BYTE_OUT);
        @(posedge CLK_SHIFT);
        model_edge();
        @(negedge CLK_SHIFT);
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [7:0]  exp_q[$];
        int          first, last, nvalid, n;

        // Reset state
        model_reset();
        repeat (2) @(negedge CLK_SHIFT);
        check("rst_valid", BYTE_VALID, 1'b0);
        check("rst_out", BYTE_OUT, 8'h00);
        check("rst_empty", FIFO_EMPTY, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_ovf", OVERFLOW, 1'b0);
        RST_SHIFT = 1'b1;

        // Single word
        dut_log.delete();
        BYTE_READY = 1'b1; RES_VALID = 1'b1; RES_IN = 16'hA55A;
        cycle();
        RES_VALID = 1'b0;
        check("t1_empty_after_push", FIFO_EMPTY, 1'b0);
        check("t1_no_byte_yet", BYTE_VALID, 1'b0);
        cycle();
        check("t1_lsb_valid", BYTE_VALID, 1'b1);
        check("t1_lsb", BYTE_OUT, 8'h5A);
        cycle();
        check("t1_msb", BYTE_OUT, 8'hA5);
        repeat (3) cycle();
        check("t1_count", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            check("t1_b0", dut_log[0], 8'h5A);
            check("t1_b1", dut_log[1], 8'hA5);
        end
        check("t1_empty_end", FIFO_EMPTY, 1'b1);
        check("t1_busy_end", BUSY, 1'b0);

        // Backpressure
        dut_log.delete();
        BYTE_READY = 1'b0; RES_VALID = 1'b1; RES_IN = 16'h1234;
        cycle();
        RES_VALID = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2_hold_valid", BYTE_VALID, 1'b1);
            check("t2_hold_out", BYTE_OUT, 8'h34);
        end
        BYTE_READY = 1'b1;
        repeat (4) cycle();
        check("t2_count", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            check("t2_b0", dut_log[0], 8'h34);
            check("t2_b1", dut_log[1], 8'h12);
        end

        // Overflow
        dut_log.delete();
        BYTE_READY = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            RES_VALID = 1'b1; RES_IN = 16'(i);
            cycle();
        end
        RES_VALID = 1'b0;
        cycle();
        check("t3_ovf_set", OVERFLOW, 1'b1);
        BYTE_READY = 1'b1;
        repeat (14) cycle();
        check("t3_count", dut_log.size(), 10);
        if (dut_log.size() == 10) begin
            for (int k = 0; k < 5; k++) begin
                check("t3_lo", dut_log[2*k], 8'(k + 1));
                check("t3_hi", dut_log[2*k+1], 8'h00);
            end
        end
        CLR_OVF = 1'b1;
        cycle();
        CLR_OVF = 1'b0;
        check("t3_ovf_clr", OVERFLOW, 1'b0);

        // Full FIFO with simultaneous pop
        dut_log.delete();
        BYTE_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            RES_VALID = 1'b1; RES_IN = 16'h1000 + 16'(i);
            cycle();
        end
        RES_VALID = 1'b0;
        check("t4_ovf_pre", OVERFLOW, 1'b0);
        BYTE_READY = 1'b1;
        cycle();
        RES_VALID = 1'b1; RES_IN = 16'hBEEF;
        cycle();
        RES_VALID = 1'b0;
        check("t4_ovf_post", OVERFLOW, 1'b0);
        repeat (14) cycle();
        check("t4_count", dut_log.size(), 12);
        if (dut_log.size() == 12) begin
            check("t4_w4_lo", dut_log[8], 8'h04);
            check("t4_beef_lo", dut_log[10], 8'hEF);
            check("t4_beef_hi", dut_log[11], 8'hBE);
        end

        // Continuous stream, one word every other cycle
        dut_log.delete();
        exp_q.delete();
        first = -1; last = -1; nvalid = 0; n = 0;
        BYTE_READY = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0 && i < 20) begin
                w = 16'($urandom);
                RES_VALID = 1'b1; RES_IN = w;
                exp_q.push_back(w[7:0]);
                exp_q.push_back(w[15:8]);
            end else begin
                RES_VALID = 1'b0;
            end
            cycle();
            if (BYTE_VALID) begin
                if (first < 0) first = n;
                last = n;
                nvalid++;
            end
            n++;
        end
        RES_VALID = 1'b0;
        check("t5_gapfree", nvalid, last - first + 1);
        check("t5_count", dut_log.size(), exp_q.size());
        if (dut_log.size() == exp_q.size()) begin
            for (int k = 0; k < exp_q.size(); k++) check("t5_byte", dut_log[k], exp_q[k]);
        end
        check("t5_ovf", OVERFLOW, 1'b0);

        // Reset right after the LSB transfer
        dut_log.delete();
        BYTE_READY = 1'b0;
        RES_VALID = 1'b1; RES_IN = 16'hC3D2;
        cycle();
        RES_IN = 16'h7788;
        cycle();
        RES_VALID = 1'b0;
        BYTE_READY = 1'b1;
        if (BYTE_VALID && BYTE_READY) dut_log.push_back(BYTE_OUT);
        @(posedge CLK_SHIFT);
        model_edge();
        #1 RST_SHIFT = 1'b0;
        #1;
        check("t6_valid_async", BYTE_VALID, 1'b0);
        check("t6_busy_async", BUSY, 1'b0);
        check("t6_empty_async", FIFO_EMPTY, 1'b1);
        check("t6_out_async", BYTE_OUT, 8'h00);
        model_reset();
        @(negedge CLK_SHIFT);
        @(negedge CLK_SHIFT);
        RST_SHIFT = 1'b1;
        repeat (5) cycle();
        check("t6_log_count", dut_log.size(), 1);
        if (dut_log.size() >= 1) check("t6_lsb", dut_log[0], 8'hD2);
        check("t6_empty", FIFO_EMPTY, 1'b1);
        check("t6_ovf", OVERFLOW, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            RES_VALID  = ($urandom_range(0, 2) != 0);
            RES_IN     = 16'($urandom);
            BYTE_READY = ($urandom_range(0, 3) != 0);
            CLR_OVF    = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
